// File: rtl/rv32_pkg.sv
// Shared RV32 fetch definitions: NOP encoding, default reset vector, fetch entry layout.
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is readable combinationally.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [Width-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(Depth):0]   count,
    output logic [Width-1:0]         head
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    // Pointer/count next state; a pop frees a slot so push-at-full is legal alongside it.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CntW'(Depth)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; emptiness is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Head and occupancy outputs.
    always_comb begin
        head  = mem[rd_ptr_q];
        count = count_q;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues in-order imem requests, buffers returned words and
// presents them to decode. Redirects flush the buffer and discard in-flight responses.
// Optional build macro IFU_MISALIGN_CHECK_EN: misaligned redirect targets raise
// fetch_misaligned for one cycle and halt fetching until the next redirect; without it
// redirect targets are forced to word alignment.
module instruction_fetch
    import rv32_pkg::*;
#(
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] ResetVector = DataWidth'(RESET_VECTOR),
    parameter int unsigned          BufDepth    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect_en,
    input  logic [DataWidth-1:0] redirect_addr,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [DataWidth-1:0] imem_addr,
    input  logic                 imem_rsp_valid,
    input  logic [DataWidth-1:0] imem_rsp_data,
    output logic [DataWidth-1:0] instruction,
    output logic [DataWidth-1:0] pc_address,
`ifdef IFU_MISALIGN_CHECK_EN
    output logic                 fetch_misaligned,
`endif
    output logic                 valid
);

    localparam int unsigned CntW = $clog2(BufDepth) + 1;
    localparam int unsigned SumW = CntW + 1;

    logic [DataWidth-1:0]   fetch_pc_q, fetch_pc_d;
    logic                   req_valid_q, req_valid_d;
    logic [CntW-1:0]        discard_q, discard_d;
    logic                   halt_q, halt_d;

    logic                   accept, drop, push, pop, buf_empty, misaligned;
    logic [DataWidth-1:0]   target;
    logic [CntW-1:0]        outstanding, out_next;
    logic [CntW-1:0]        buf_count, buf_next;
    logic [DataWidth-1:0]   pcq_head;
    logic [2*DataWidth-1:0] buf_head;

    // PCs of accepted requests, popped by each response (stale or not) to stay aligned.
    fetch_fifo #(
        .Depth (BufDepth),
        .Width (DataWidth)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (fetch_pc_q),
        .pop       (imem_rsp_valid),
        .flush     (1'b0),
        .count     (outstanding),
        .head      (pcq_head)
    );

    // Decode-facing buffer of {pc, instr}.
    fetch_fifo #(
        .Depth (BufDepth),
        .Width (2 * DataWidth)
    ) u_inst_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({pcq_head, imem_rsp_data}),
        .pop       (pop),
        .flush     (redirect_en),
        .count     (buf_count),
        .head      (buf_head)
    );

    // Handshake decode, discard accounting and next PC / request state.
    always_comb begin
`ifdef IFU_MISALIGN_CHECK_EN
        target     = redirect_addr;
        misaligned = |redirect_addr[1:0];
`else
        target     = redirect_addr & ~DataWidth'(3);
        misaligned = 1'b0;
`endif
        accept    = req_valid_q && imem_req_ready;
        // Responses landing in the redirect cycle belong to the old stream.
        drop      = imem_rsp_valid && (redirect_en || (discard_q != '0));
        push      = imem_rsp_valid && !drop;
        buf_empty = (buf_count == '0);
        pop       = !buf_empty && !stall && !redirect_en;
        out_next  = outstanding + CntW'(accept) - CntW'(imem_rsp_valid);

        if (redirect_en) begin
            buf_next = '0;
        end else begin
            buf_next = buf_count + CntW'(push) - CntW'(pop);
        end

        discard_d = discard_q;
        if (redirect_en) begin
            // Everything still in flight after this edge is old-stream.
            discard_d = out_next;
        end else if (imem_rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - CntW'(1);
        end

        fetch_pc_d = fetch_pc_q;
        halt_d     = halt_q;
        if (redirect_en) begin
            fetch_pc_d = target;
            halt_d     = misaligned;
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + DataWidth'(4);
        end

        // Occupancy only falls while a request waits, so a raised request stays raised.
        req_valid_d = !halt_d &&
                      ((SumW'(buf_next) + SumW'(out_next)) < SumW'(BufDepth));
    end

    // Fetch control state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q  <= ResetVector;
            req_valid_q <= 1'b0;
            discard_q   <= '0;
            halt_q      <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_valid_q <= req_valid_d;
            discard_q   <= discard_d;
            halt_q      <= halt_d;
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    logic misaligned_q;

    // One-cycle pulse after a misaligned redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= redirect_en && misaligned;
        end
    end

    assign fetch_misaligned = misaligned_q;
`endif

    // Output drive: buffer head, or NOP when empty.
    always_comb begin
        imem_req_valid = req_valid_q;
        imem_addr      = fetch_pc_q;
        valid          = !buf_empty;
        instruction    = buf_empty ? DataWidth'(NOP_INSTR) : buf_head[DataWidth-1:0];
        pc_address     = buf_empty ? '0 : buf_head[2*DataWidth-1:DataWidth];
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a stream-level reference model.
module tb_instruction_fetch;

    localparam int unsigned BUF = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst, stall, redirect_en, imem_req_valid, imem_req_ready;
    logic        imem_rsp_valid, valid;
    logic [31:0] redirect_addr, imem_addr, imem_rsp_data, instruction, pc_address;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    instruction_fetch #(
        .DataWidth   (32),
        .ResetVector (32'h0000_0000),
        .BufDepth    (BUF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_en    (redirect_en),
        .redirect_addr  (redirect_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instruction    (instruction),
        .pc_address     (pc_address),
`ifdef IFU_MISALIGN_CHECK_EN
        .fetch_misaligned (fetch_misaligned),
`endif
        .valid          (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } dent_t;
    typedef struct packed { logic [31:0] addr; logic stale; } infl_t;
    typedef struct { int due; logic [31:0] addr; } mreq_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: decode-visible words, fetches in flight, expected fetch PC.
    dent_t       dq[$];
    infl_t       inflight[$];
    mreq_t       memq[$];
    logic [31:0] exp_fetch;
    bit          exp_halt, exp_mis;
    int          last_due, cyc, lat, first_valid_cyc;
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        acc_log.delete();
        pop_log.delete();
    endtask

    // Per-cycle comparison of every meaningful DUT output against the model.
    task automatic compare();
        chk("valid", {31'b0, valid}, {31'b0, dq.size() > 0});
        if (dq.size() > 0) begin
            chk("pc_address", pc_address, dq[0].pc);
            chk("instruction", instruction, dq[0].instr);
            if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        end else begin
            chk("instruction_nop", instruction, NOP);
        end
        chk("imem_req_valid", {31'b0, imem_req_valid},
            {31'b0, !exp_halt && (dq.size() + inflight.size() < BUF)});
        if (imem_req_valid) chk("imem_addr", imem_addr, exp_fetch);
        chk("outstanding_cap", {31'b0, inflight.size() <= BUF}, 32'd1);
`ifdef IFU_MISALIGN_CHECK_EN
        chk("fetch_misaligned", {31'b0, fetch_misaligned}, {31'b0, exp_mis});
`endif
    endtask

    // One clock: drive inputs, compare, advance model, step the clock.
    task automatic cycle(input bit st, input bit rdy, input bit rd, input logic [31:0] ra);
        bit          acc, do_pop;
        logic [31:0] aaddr, tgt;
        infl_t       e;
        int          due;
        stall = st; imem_req_ready = rdy; redirect_en = rd; redirect_addr = ra;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        compare();
        acc    = imem_req_valid && rdy;
        aaddr  = imem_addr;
        do_pop = (dq.size() > 0) && !st && !rd;
        if (do_pop) pop_log.push_back(dq[0].pc);
        if (imem_rsp_valid) begin
            void'(memq.pop_front());
            if (inflight.size() > 0) begin
                e = inflight.pop_front();
                if (!e.stale && !rd) dq.push_back({e.addr, mem_word(e.addr)});
            end
        end
        if (do_pop) void'(dq.pop_front());
        if (acc) begin
            inflight.push_back({aaddr, 1'b0});
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            memq.push_back('{due: due, addr: aaddr});
            last_due = due;
            acc_log.push_back(aaddr);
            exp_fetch = aaddr + 32'd4;
        end
        exp_mis = 1'b0;
        if (rd) begin
            dq.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
`ifdef IFU_MISALIGN_CHECK_EN
            tgt      = ra;
            exp_halt = (ra[1:0] != 2'b00);
            exp_mis  = exp_halt;
`else
            tgt = {ra[31:2], 2'b00};
`endif
            exp_fetch = tgt;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        stall = 0; imem_req_ready = 0; redirect_en = 0; redirect_addr = 0;
        imem_rsp_valid = 0; imem_rsp_data = 0;
        rst = 1'b0;
        #1;
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_instruction", instruction, NOP);
        chk("rst_pc_address", pc_address, 32'h0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
`ifdef IFU_MISALIGN_CHECK_EN
        chk("rst_fetch_misaligned", {31'b0, fetch_misaligned}, 32'd0);
`endif
        dq.delete(); inflight.delete(); memq.delete(); clear_logs();
        exp_fetch = 32'h0; exp_halt = 0; exp_mis = 0;
        last_due = -1; cyc = 0; lat = 1; first_valid_cyc = -1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        @(negedge clk);

        // Streaming fetch from reset, 1-cycle latency.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0);
        chk("fetch0", qget(acc_log, 0), 32'h0);
        chk("fetch1", qget(acc_log, 1), 32'h4);
        chk("fetch2", qget(acc_log, 2), 32'h8);
        chk("first_valid_cycle", first_valid_cyc, 32'd2);
        chk("first_pop_pc", qget(pop_log, 0), 32'h0);

        // Stall with the buffer full, then release.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", {31'b0, valid}, 32'd1);
            chk("stall_pc", pc_address, 32'h0);
            chk("stall_instr", instruction, 32'h1234_5678);
            chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
            cycle(1, 1, 0, 0);
        end
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);
        chk("pop0", qget(pop_log, 0), 32'h0);
        chk("pop1", qget(pop_log, 1), 32'h4);
        chk("pop2", qget(pop_log, 2), 32'h8);

        // Memory not ready: request held at 0x8.
        do_reset();
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        for (int k = 2; k < 8; k++) begin
            if (k >= 3 && k <= 6) begin
                chk("hold_req_valid", {31'b0, imem_req_valid}, 32'd1);
                chk("hold_addr", imem_addr, 32'h8);
            end
            cycle(0, 0, 0, 0);
        end
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);

        // Redirect with two requests outstanding, 3-cycle latency.
        do_reset();
        lat = 3;
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        clear_logs();
        cycle(0, 1, 1, 32'h100);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0);
        chk("redir_first_fetch", qget(acc_log, 0), 32'h100);
        chk("redir_first_pop", qget(pop_log, 0), 32'h100);
        chk("redir_valid_cycle", first_valid_cyc, 32'd8);

        // Redirect coinciding with a response and a stall.
        do_reset();
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        clear_logs();
        cycle(1, 1, 1, 32'h40);
        chk("rs_valid", {31'b0, valid}, 32'd0);
        chk("rs_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rs_addr", imem_addr, 32'h40);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0);
        chk("rs_first_pop", qget(pop_log, 0), 32'h40);

        // Misaligned redirect target.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 32'h102);
        clear_logs();
`ifdef IFU_MISALIGN_CHECK_EN
        chk("mis_pulse", {31'b0, fetch_misaligned}, 32'd1);
        cycle(0, 1, 0, 0);
        chk("mis_pulse_end", {31'b0, fetch_misaligned}, 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
        chk("mis_no_fetch", acc_log.size(), 32'd0);
        cycle(0, 1, 1, 32'h200);
        clear_logs();
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
        chk("mis_resume", qget(acc_log, 0), 32'h200);
`else
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);
        chk("align_fetch", qget(acc_log, 0), 32'h100);
        chk("align_pop", qget(pop_log, 0), 32'h100);
`endif

        // PC wrap at the top of the address space.
        do_reset();
        cycle(0, 1, 1, 32'hFFFF_FFFC);
        clear_logs();
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);
        chk("wrap_fetch0", qget(acc_log, 0), 32'hFFFF_FFFC);
        chk("wrap_fetch1", qget(acc_log, 1), 32'h0);
        chk("wrap_pop1", qget(pop_log, 1), 32'h0);

        // Mixed stalls, backpressure, varying latency, back-to-back redirects.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            lat = 1 + (i % 3);
            cycle((i % 5) == 3, (i % 7) != 2, (i == 20) || (i == 21) || (i == 40),
                  (i == 20) ? 32'h300 : (i == 21) ? 32'h400 : 32'h500);
        end
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of decode.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned words in a small FIFO and presents instruction, pc_address and valid to decode.
- Honours decode stalls (load-use) and redirects (taken branch, jal, jalr), discarding in-flight fetches on redirect.

Parameters:
- DataWidth, 32, width of PC and instruction.
- ResetVector, 32'h0000_0000, first fetch address after reset.
- BufDepth, 2, fetch FIFO entries; also caps requests in flight (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  decode cannot accept this cycle; hold outputs.
- redirect_en  in  1  redirect fetch this cycle.
- redirect_addr  in  DataWidth  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  DataWidth  fetch address.
- imem_rsp_valid  in  1  response word valid.
- imem_rsp_data  in  DataWidth  response word.
- instruction  out  DataWidth  instruction to decode.
- pc_address  out  DataWidth  PC of instruction.
- valid  out  1  instruction/pc_address meaningful.

Behaviour:
- Reset (rst low, async): fetch_pc=ResetVector, FIFO empty, outstanding=0, discard=0, imem_req_valid=0, valid=0, instruction=32'h0000_0013 (NOP), pc_address=0.
- Request issue: imem_req_valid=1 when fifo_count+outstanding<BufDepth; first possible cycle is the first edge after rst rises. imem_addr=fetch_pc.
- On handshake (valid&&ready): fetch_pc+=4 (wraps mod 2^DataWidth) and outstanding++.
- Once asserted, imem_req_valid stays high until accepted. imem_addr changes only on redirect.
- Responses: exactly one per accepted request, in order, latency ≥1 cycle.
- Each response decrements outstanding. If discard>0, the word is dropped and discard decrements; otherwise it is pushed with its PC (tracked PC queue).
- Decode output: instruction, pc_address and valid come from the FIFO head registers. valid=FIFO non-empty.
- Pop when valid&&!stall. While stall=1, all three outputs hold.
- When the FIFO is empty, instruction=NOP.
- Latency: response in cycle N is visible at decode in N+1. Simultaneous push and pop is allowed at full and at empty.
- Redirect (cycle N), which has priority over stall:
  - FIFO flushed; valid=0 in N+1.
  - discard = outstanding + (accept in N ? 1 : 0) − (response in N ? 1 : 0), counting responses in N as discarded.
  - fetch_pc=redirect_addr; imem_addr=redirect_addr in N+1.
  - Any request accepted in N belongs to the old stream.
- Redirect while discard>0: recompute discard from current counts; no word of any old stream ever reaches decode.
- Back-to-back redirects: the last one wins.
- Counter widths are $clog2(BufDepth)+1; outstanding never exceeds BufDepth.

Optional Feature:
- Macro IFU_MISALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit), pulsed for one cycle in N+1 when redirect_addr[1:0]!=0.
  - The target is not fetched; request issue halts until the next redirect.
  - valid stays 0 during the halt.
- Undefined:
  - No extra port; target forced to {redirect_addr[DataWidth-1:2],2'b00}.

Decomposition:
- Shared package rv32_pkg:
  - NOP_INSTR=32'h0000_0013.
  - RESET_VECTOR default.
  - typedef fetch_entry_t {pc, instr}.
- Sub-module fetch_fifo (parameterised depth, push/pop/flush, count, head outputs). The PC queue for in-flight requests reuses fetch_fifo.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle response latency -> fetches 0x0,0x4,0x8; valid=1 with pc_address 0x0 one cycle after the first response; instruction matches memory.
- stall=1 for 3 cycles with FIFO full -> outputs frozen, imem_req_valid=0 (count 2 + outstanding 0); release -> in-order pops, no duplicate or lost PC.
- imem_req_ready low 4 cycles -> imem_req_valid held 1, imem_addr stable at 0x8.
- Redirect to 0x100 with 2 requests outstanding (3-cycle latency) -> both old responses dropped; next valid shows pc_address=0x100.
- Redirect coinciding with a response and with stall=1 -> response discarded, valid=0 next cycle, next fetch at target.
- With IFU_MISALIGN_CHECK_EN, redirect to 0x102 -> fetch_misaligned pulses 1 cycle, no request issued until redirect to 0x200. Without the macro -> fetch at 0x100.
